// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS front end: the PC-stage state
//               enum, default reset/exception vectors, the instruction width
//               and the branch-target helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_WIDTH-1:0] EXC_VECTOR_DEFAULT   = 32'h0000_0180;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    // Branch target: PC+4 of the branch plus the word-scaled signed immediate.
    function automatic logic [INSTR_WIDTH-1:0] branch_target(
        input logic [INSTR_WIDTH-1:0] pc_plus4,
        input logic [15:0]            offset
    );
        return pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_target_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_gen
// Description : Combinational next-PC target generator. Computes the
//               sequential, branch, jump and jump-register targets and picks
//               one by priority jump_reg > jump > branch > sequential.
//               Optional macro PC_ALIGN_CHECK_EN: a misaligned jump-register
//               target is replaced by EXC_VECTOR and flagged on
//               o_align_fault; without it the low two bits are cleared.
// Ports       : i_pc              - current fetch address
//               i_id_pc_plus4     - PC+4 of the instruction in decode
//               i_branch_taken/i_branch_offset, i_jump/i_jump_index,
//               i_jump_reg/i_jump_reg_target - redirect requests
//               o_seq_target      - i_pc + 4
//               o_target          - selected next PC
//               o_redirect        - a redirect was selected
//               o_align_fault     - (PC_ALIGN_CHECK_EN only) misaligned JR
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_gen
    import mips_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic [INSTR_WIDTH-1:0] i_pc,
    input  logic [INSTR_WIDTH-1:0] i_id_pc_plus4,
    input  logic                   i_branch_taken,
    input  logic [15:0]            i_branch_offset,
    input  logic                   i_jump,
    input  logic [25:0]            i_jump_index,
    input  logic                   i_jump_reg,
    input  logic [INSTR_WIDTH-1:0] i_jump_reg_target,
    output logic [INSTR_WIDTH-1:0] o_seq_target,
    output logic [INSTR_WIDTH-1:0] o_target,
    output logic                   o_redirect
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                   o_align_fault
`endif
);

    logic [INSTR_WIDTH-1:0] w_seq_target;
    logic [INSTR_WIDTH-1:0] w_branch_target;
    logic [INSTR_WIDTH-1:0] w_jump_target;
    logic [INSTR_WIDTH-1:0] w_jr_target;

    assign w_seq_target    = i_pc + 32'd4;
    assign w_branch_target = branch_target(i_id_pc_plus4, i_branch_offset);
    // J/JAL stay inside the 256 MB region of the delay-slot address.
    assign w_jump_target   = {i_id_pc_plus4[31:28], i_jump_index, 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    logic w_jr_misaligned;

    assign w_jr_misaligned = |i_jump_reg_target[1:0];
    assign w_jr_target     = w_jr_misaligned ? EXC_VECTOR : i_jump_reg_target;
    assign o_align_fault   = i_jump_reg & w_jr_misaligned;
`else
    // EXC_VECTOR only matters when alignment checking is built in; the
    // target is simply word-aligned here.
    assign w_jr_target = i_jump_reg_target & ~32'h0000_0003;
`endif

    always_comb begin
        o_target   = w_seq_target;
        o_redirect = 1'b0;
        if (i_jump_reg) begin
            o_target   = w_jr_target;
            o_redirect = 1'b1;
        end else if (i_jump) begin
            o_target   = w_jump_target;
            o_redirect = 1'b1;
        end else if (i_branch_taken) begin
            o_target   = w_branch_target;
            o_redirect = 1'b1;
        end
    end

    assign o_seq_target = w_seq_target;

endmodule : pc_target_gen
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit
// Description : Program-counter stage. Drives the synchronous instruction
//               memory address, applies halt/redirect requests from decode,
//               squashes the in-flight wrong-path fetch through a registered
//               fetch_valid, and counts delivered instructions.
//               Optional macro PC_ALIGN_CHECK_EN enables the jump-register
//               alignment fault (fault / fault_addr); otherwise both are 0.
// Ports       : clk, rst (async, active-high)
//               stall            - decode hazard stall, holds the stage
//               id_pc_plus4      - PC+4 of the instruction in decode
//               branch_taken, branch_offset, jump, jump_index,
//               jump_reg, jump_reg_target, halt, resume - control from decode
//               pc, pc_plus4     - fetch address and its successor
//               fetch_valid      - fetch output is valid and on-path
//               instr_count      - delivered instruction count (wraps)
//               fault, fault_addr- alignment fault pulse and target
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [INSTR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [INSTR_WIDTH-1:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [INSTR_WIDTH-1:0] id_pc_plus4,
    input  logic                   branch_taken,
    input  logic [15:0]            branch_offset,
    input  logic                   jump,
    input  logic [25:0]            jump_index,
    input  logic                   jump_reg,
    input  logic [INSTR_WIDTH-1:0] jump_reg_target,
    input  logic                   halt,
    input  logic                   resume,
    output logic [INSTR_WIDTH-1:0] pc,
    output logic [INSTR_WIDTH-1:0] pc_plus4,
    output logic                   fetch_valid,
    output logic [INSTR_WIDTH-1:0] instr_count,
    output logic                   fault,
    output logic [INSTR_WIDTH-1:0] fault_addr
);

    pc_state_e              r_state;
    pc_state_e              w_state_next;
    logic [INSTR_WIDTH-1:0] r_pc;
    logic [INSTR_WIDTH-1:0] w_pc_next;
    logic                   r_fetch_valid;
    logic                   w_fetch_valid_next;
    logic [INSTR_WIDTH-1:0] r_instr_count;
    logic [INSTR_WIDTH-1:0] w_seq_target;
    logic [INSTR_WIDTH-1:0] w_target;
    logic                   w_redirect;
    logic                   w_align_fault;
    logic                   w_fault_next;

    pc_target_gen #(
        .EXC_VECTOR        (EXC_VECTOR)
    ) u_target_gen (
        .i_pc              (r_pc),
        .i_id_pc_plus4     (id_pc_plus4),
        .i_branch_taken    (branch_taken),
        .i_branch_offset   (branch_offset),
        .i_jump            (jump),
        .i_jump_index      (jump_index),
        .i_jump_reg        (jump_reg),
        .i_jump_reg_target (jump_reg_target),
        .o_seq_target      (w_seq_target),
        .o_target          (w_target),
        .o_redirect        (w_redirect)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .o_align_fault     (w_align_fault)
`endif
    );

`ifndef PC_ALIGN_CHECK_EN
    assign w_align_fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_valid_next = r_fetch_valid;
        w_fault_next       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        // Park on the instruction after the halt so resume
                        // restarts there.
                        w_pc_next          = id_pc_plus4;
                        w_fetch_valid_next = 1'b0;
                        w_state_next       = ST_HALT;
                    end else begin
                        w_pc_next          = w_target;
                        // A redirect squashes the fetch already in flight.
                        w_fetch_valid_next = ~w_redirect;
                        w_fault_next       = w_align_fault;
                    end
                end
            end
            ST_HALT: begin
                w_fetch_valid_next = 1'b0;
                if (resume) begin
                    // Fetch of the parked PC is issued this cycle.
                    w_state_next       = ST_RUN;
                    w_pc_next          = w_seq_target;
                    w_fetch_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next       = ST_RUN;
                w_fetch_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC, fetch-valid and delivered-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_fetch_valid <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_fetch_valid <= w_fetch_valid_next;
            if (r_fetch_valid && !stall) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic                   r_fault;
    logic [INSTR_WIDTH-1:0] r_fault_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_fault <= w_fault_next;
            if (w_fault_next) begin
                r_fault_addr <= jump_reg_target;
            end
        end
    end

    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;
`else
    assign fault      = w_fault_next;
    assign fault_addr = '0;
`endif

    assign pc          = r_pc;
    assign pc_plus4    = w_seq_target;
    assign fetch_valid = r_fetch_valid;
    assign instr_count = r_instr_count;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_unit
// Description : Self-checking testbench for pc_unit. Directed scenarios plus
//               randomized traffic checked against a behavioural model of
//               the PC stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] id_pc_plus4;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jump_reg_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] instr_count;
    logic        fault;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_fv;
    logic        m_halted;
    logic [31:0] m_count;
    logic        m_fault;
    logic [31:0] m_fault_addr;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_pc_plus4     (id_pc_plus4),
        .branch_taken    (branch_taken),
        .branch_offset   (branch_offset),
        .jump            (jump),
        .jump_index      (jump_index),
        .jump_reg        (jump_reg),
        .jump_reg_target (jump_reg_target),
        .halt            (halt),
        .resume          (resume),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .instr_count     (instr_count),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    function automatic void model_reset();
        m_pc         = 32'h0;
        m_fv         = 1'b0;
        m_halted     = 1'b0;
        m_count      = 32'h0;
        m_fault      = 1'b0;
        m_fault_addr = 32'h0;
    endfunction

    // One clock of the PC stage from the current input values.
    function automatic void model_step();
        logic [31:0] npc;
        logic        nfv;
        logic        nhalted;
        logic signed [31:0] soff;
        npc     = m_pc;
        nfv     = m_fv;
        nhalted = m_halted;
        if (m_fv && !stall) m_count = m_count + 1;
        m_fault = 1'b0;
        if (m_halted) begin
            nfv = 1'b0;
            if (resume) begin
                nhalted = 1'b0;
                npc     = m_pc + 4;
                nfv     = 1'b1;
            end
        end else if (!stall) begin
            if (halt) begin
                npc = id_pc_plus4; nfv = 1'b0; nhalted = 1'b1;
            end else if (jump_reg) begin
                nfv = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                if (jump_reg_target % 4 != 0) begin
                    npc          = 32'h180;
                    m_fault      = 1'b1;
                    m_fault_addr = jump_reg_target;
                end else begin
                    npc = jump_reg_target;
                end
`else
                npc = jump_reg_target - (jump_reg_target % 4);
`endif
            end else if (jump) begin
                npc = (id_pc_plus4 & 32'hF000_0000) + 32'(jump_index) * 4;
                nfv = 1'b0;
            end else if (branch_taken) begin
                soff = 32'(signed'(branch_offset));
                npc  = id_pc_plus4 + 32'(soff * 4);
                nfv  = 1'b0;
            end else begin
                npc = m_pc + 4;
                nfv = 1'b1;
            end
        end
        m_pc     = npc;
        m_fv     = nfv;
        m_halted = nhalted;
    endfunction

    task automatic drive_idle();
        stall = 0; branch_taken = 0; jump = 0; jump_reg = 0; halt = 0; resume = 0;
        id_pc_plus4 = 0; branch_offset = 0; jump_index = 0; jump_reg_target = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
        n_checks++; if (fetch_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv: got %b exp 0", fetch_valid); end
        n_checks++; if (instr_count !== 32'h0) begin n_errors++; $display("FAIL reset_count: got %0d exp 0", instr_count); end
        n_checks++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin n_errors++; $display("FAIL reset_fault: got %b/%h exp 0/0", fault, fault_addr); end
    endtask

    task automatic test_sequential();
        drive_idle();
        tick();
        n_checks++; if (pc !== 32'h4 || fetch_valid !== 1'b1) begin n_errors++; $display("FAIL seq_1: got pc %h fv %b exp 4 1", pc, fetch_valid); end
        tick();
        n_checks++; if (pc !== 32'h8 || fetch_valid !== 1'b1) begin n_errors++; $display("FAIL seq_2: got pc %h fv %b exp 8 1", pc, fetch_valid); end
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (instr_count !== 32'd9) begin n_errors++; $display("FAIL seq_count: got %0d exp 9", instr_count); end
        n_checks++; if (pc !== 32'h28 || pc_plus4 !== 32'h2C) begin n_errors++; $display("FAIL seq_pc10: got %h/%h exp 28/2c", pc, pc_plus4); end
    endtask

    task automatic test_branch();
        id_pc_plus4 = 32'h100; branch_offset = 16'hFFFE; branch_taken = 1;
        tick();
        drive_idle();
        n_checks++; if (pc !== 32'hF8 || fetch_valid !== 1'b0) begin n_errors++; $display("FAIL branch_target: got pc %h fv %b exp f8 0", pc, fetch_valid); end
        tick();
        n_checks++; if (pc !== 32'hFC || fetch_valid !== 1'b1) begin n_errors++; $display("FAIL branch_after: got pc %h fv %b exp fc 1", pc, fetch_valid); end
    endtask

    task automatic test_stall_jump();
        logic [31:0] pc0, cnt0;
        logic        fv0;
        pc0 = pc; cnt0 = instr_count; fv0 = fetch_valid;
        stall = 1; jump = 1; branch_taken = 1;
        id_pc_plus4 = 32'h1000_0000; jump_index = 26'h40; branch_offset = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (pc !== pc0 || instr_count !== cnt0 || fetch_valid !== fv0) begin
                n_errors++; $display("FAIL stall_hold: got pc %h cnt %0d fv %b exp %h %0d %b", pc, instr_count, fetch_valid, pc0, cnt0, fv0);
            end
        end
        stall = 0;
        tick();
        drive_idle();
        n_checks++; if (pc !== 32'h1000_0100 || fetch_valid !== 1'b0) begin n_errors++; $display("FAIL jump_wins: got pc %h fv %b exp 10000100 0", pc, fetch_valid); end
        tick();
    endtask

    task automatic test_halt();
        logic [31:0] cnt0;
        id_pc_plus4 = 32'h20; halt = 1; jump = 1; jump_index = 26'h123;
        tick();
        drive_idle();
        cnt0 = instr_count;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (pc !== 32'h20 || fetch_valid !== 1'b0) begin n_errors++; $display("FAIL halt_hold: got pc %h fv %b exp 20 0", pc, fetch_valid); end
            stall = 1'($urandom); jump = 1; branch_taken = 1; halt = 1; jump_reg = 1;
            id_pc_plus4 = $urandom; jump_reg_target = $urandom;
            tick();
        end
        drive_idle();
        n_checks++; if (instr_count !== cnt0) begin n_errors++; $display("FAIL halt_count: got %0d exp %0d", instr_count, cnt0); end
        resume = 1;
        tick();
        resume = 0;
        n_checks++; if (pc !== 32'h24 || fetch_valid !== 1'b1) begin n_errors++; $display("FAIL resume: got pc %h fv %b exp 24 1", pc, fetch_valid); end
    endtask

    task automatic test_jump_reg();
        jump_reg = 1; jump_reg_target = 32'h1002;
        tick();
        drive_idle();
`ifdef PC_ALIGN_CHECK_EN
        n_checks++; if (pc !== 32'h180 || fault !== 1'b1 || fault_addr !== 32'h1002) begin
            n_errors++; $display("FAIL jr_fault: got pc %h fault %b addr %h exp 180 1 1002", pc, fault, fault_addr);
        end
        tick();
        n_checks++; if (fault !== 1'b0 || fault_addr !== 32'h1002) begin n_errors++; $display("FAIL jr_fault_pulse: got %b/%h exp 0/1002", fault, fault_addr); end
`else
        n_checks++; if (pc !== 32'h1000 || fault !== 1'b0 || fault_addr !== 32'h0) begin
            n_errors++; $display("FAIL jr_align: got pc %h fault %b addr %h exp 1000 0 0", pc, fault, fault_addr);
        end
        tick();
        n_checks++; if (pc !== 32'h1004 || fault !== 1'b0) begin n_errors++; $display("FAIL jr_after: got pc %h fault %b exp 1004 0", pc, fault); end
`endif
    endtask

    task automatic test_wrap();
        jump_reg = 1; jump_reg_target = 32'hFFFF_FFFC;
        tick();
        drive_idle();
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_setup: got %h exp fffffffc", pc); end
        tick();
        n_checks++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin n_errors++; $display("FAIL wrap: got %h/%h exp 0/4", pc, pc_plus4); end
    endtask

    task automatic test_async_reset();
        id_pc_plus4 = 32'h500; halt = 1;
        tick();
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (pc !== 32'h0 || fetch_valid !== 1'b0 || instr_count !== 32'h0) begin
            n_errors++; $display("FAIL async_reset: got pc %h fv %b cnt %0d exp 0 0 0", pc, fetch_valid, instr_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick();
        n_checks++; if (pc !== 32'h4 || fetch_valid !== 1'b1) begin n_errors++; $display("FAIL reset_from_halt_run: got pc %h fv %b exp 4 1", pc, fetch_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            stall           = ($urandom_range(0, 99) < 20);
            halt            = ($urandom_range(0, 99) < 4);
            jump_reg        = ($urandom_range(0, 99) < 10);
            jump            = ($urandom_range(0, 99) < 10);
            branch_taken    = ($urandom_range(0, 99) < 15);
            resume          = ($urandom_range(0, 99) < 25);
            id_pc_plus4     = $urandom;
            branch_offset   = 16'($urandom);
            jump_index      = 26'($urandom);
            jump_reg_target = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            tick();
            n_checks++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin n_errors++; $display("FAIL rand_pc[%0d]: got %h/%h exp %h", i, pc, pc_plus4, m_pc); end
            n_checks++; if (fetch_valid !== m_fv) begin n_errors++; $display("FAIL rand_fv[%0d]: got %b exp %b", i, fetch_valid, m_fv); end
            n_checks++; if (instr_count !== m_count) begin n_errors++; $display("FAIL rand_count[%0d]: got %0d exp %0d", i, instr_count, m_count); end
            n_checks++; if (fault !== m_fault || fault_addr !== m_fault_addr) begin n_errors++; $display("FAIL rand_fault[%0d]: got %b/%h exp %b/%h", i, fault, fault_addr, m_fault, m_fault_addr); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall_jump();
        test_halt();
        test_jump_reg();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_unit
`default_nettype wire
